ctrl_iload: RTL and testbench

Instruction loader for the controller: the write side of instruction memory.
- Accepts a narrow valid/ready word stream from the host/config port.
- Packs beats into one ctrl::allocInstr_s word per instruction and writes consecutive instruction-memory addresses.
- The fetch stage reads these words back later.
- prog_valid tells the controller that a complete program is resident and fetch is allowed.

---
 rtl/ctrl_pkg.sv | 18 +
 rtl/ctrl_iload_pack.sv | 37 +++
 rtl/ctrl_iload.sv | 74 +++++++
 tb/tb_ctrl_iload.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl: shared controller widths, instruction format and loader state encoding
package ctrl;
  localparam int INSTR_ADDRESS_WIDTH = 8;
  localparam int ILOAD_BUS_WIDTH = 32;
  localparam int VECTOR_ID_WIDTH = 8;
  localparam int REG_FILE_ADDRESS_WIDTH = 4;
  localparam int DATA_RAM_ADDRESS_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} ilState_e;
  typedef struct packed {
    logic [3:0] flags;
    logic [DATA_RAM_ADDRESS_WIDTH-1:0] ram_addr;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] rs2;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] rs1;
    logic [REG_FILE_ADDRESS_WIDTH-1:0] rd;
    logic [VECTOR_ID_WIDTH-1:0] vec_id;
    logic [7:0] opcode;
  } allocInstr_s;
endpackage

// File: rtl/ctrl_iload_pack.sv
// ctrl_iload_pack: beat counter and LSB-first assembly of stream beats into one instruction
module ctrl_iload_pack #(
  parameter int BUSWIDTH = 32,
  parameter int IWIDTH = 48,
  parameter int NBEATS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic [BUSWIDTH-1:0] data,
  output logic [IWIDTH-1:0] word,
  output logic beat_last
);
  localparam int CW = NBEATS > 1 ? $clog2(NBEATS) : 1;
  logic [CW-1:0] cnt;
  logic [IWIDTH-1:0] sr;
  logic [NBEATS*BUSWIDTH-1:0] ext;
  assign beat_last = cnt == CW'(NBEATS-1);
  assign word = sr;
  // bits of the final beat above IWIDTH fall off in the truncating cast
  always_comb begin
    ext = (NBEATS*BUSWIDTH)'(sr);
    ext[cnt*BUSWIDTH +: BUSWIDTH] = data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sr <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      sr <= IWIDTH'(ext);
      cnt <= beat_last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ctrl_iload.sv
// ctrl_iload: loads a program from a narrow word stream into consecutive instruction-memory words
module ctrl_iload
  import ctrl::*;
#(
  parameter int BUSWIDTH = ILOAD_BUS_WIDTH,
  parameter int IAWIDTH = INSTR_ADDRESS_WIDTH,
  parameter int IWIDTH = $bits(allocInstr_s)
) (
  input  logic clk,
  input  logic rst,
  input  logic load_start,
  input  logic [IAWIDTH-1:0] load_base,
  input  logic [IAWIDTH-1:0] load_len,
  input  logic [BUSWIDTH-1:0] s_data,
  input  logic s_valid,
  output logic s_ready,
  output logic imem_we,
  output logic [IAWIDTH-1:0] imem_addr,
  output allocInstr_s imem_wdata,
  output logic busy,
  output logic done,
  output logic prog_valid
);
  localparam int NBEATS = (IWIDTH + BUSWIDTH - 1) / BUSWIDTH;
  ilState_e st, nxt;
  logic [IAWIDTH-1:0] addr;
  logic [IAWIDTH:0] rem;
  logic [IWIDTH-1:0] word;
  logic beat_last;
  allocInstr_s held;
  ctrl_iload_pack #(.BUSWIDTH(BUSWIDTH), .IWIDTH(IWIDTH), .NBEATS(NBEATS)) u_pack (
    .clk(clk),
    .rst(rst),
    .clr(st == WRITE),
    .en(s_valid && s_ready),
    .data(s_data),
    .word(word),
    .beat_last(beat_last)
  );
  assign s_ready = st == RECV;
  assign imem_we = st == WRITE;
  assign busy = st == RECV || st == WRITE;
  assign done = st == DONE;
  assign imem_addr = addr;
  assign imem_wdata = st == WRITE ? allocInstr_s'(word) : held;
  always_comb begin
    nxt = st == IDLE ? (load_start ? RECV : IDLE) :
          st == RECV ? (s_valid && beat_last ? WRITE : RECV) :
          st == WRITE ? (rem == (IAWIDTH+1)'(1) ? DONE : RECV) : IDLE;
  end
  // a zero length sets the top bit of rem, giving a full 2^IAWIDTH load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      addr <= '0;
      rem <= '0;
      held <= '0;
      prog_valid <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && load_start) begin
        addr <= load_base;
        rem <= {load_len == '0, load_len};
        prog_valid <= 1'b0;
      end
      if (st == WRITE) begin
        addr <= addr + 1'b1;
        rem <= rem - 1'b1;
        held <= allocInstr_s'(word);
        if (rem == (IAWIDTH+1)'(1)) prog_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_iload.sv
// tb_ctrl_iload: scoreboard bench for the instruction loader
module tb_ctrl_iload;
  localparam int IAW = 8, IW = 48;
  logic clk = 0, rst = 0, load_start = 0, s_valid = 0;
  logic [IAW-1:0] load_base = 0, load_len = 0;
  logic [31:0] s_data = 0;
  logic s_ready, imem_we, busy, done, prog_valid;
  logic [IAW-1:0] imem_addr;
  ctrl::allocInstr_s imem_wdata;
  int checks = 0, failures = 0, cyc = 0, t0 = 0;
  logic [IAW+IW-1:0] sb[$];
  ctrl_iload dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .prog_valid(prog_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst && imem_we) begin
      if (sb.size() == 0) chk("extra_write", 1, 0);
      else begin
        logic [IAW+IW-1:0] e;
        logic [IW-1:0] w;
        e = sb.pop_front();
        w = imem_wdata;
        chk("wr_addr", 64'(imem_addr), 64'(e[IAW+IW-1:IW]));
        chk("wr_data", 64'(w), 64'(e[IW-1:0]));
        chk("wr_ready", 64'(s_ready), 0);
      end
    end
  end
  task automatic start(input logic [IAW-1:0] b, input logic [IAW-1:0] l);
    @(negedge clk);
    load_start = 1; load_base = b; load_len = l;
    @(negedge clk);
    load_start = 0; load_base = 8'hAA; load_len = 8'h55;
    t0 = cyc;
    chk("start_busy", 64'(busy), 1);
    chk("start_pv", 64'(prog_valid), 0);
  endtask
  task automatic beat(input logic [31:0] d, input int gap, input bit poke);
    for (int n = 0; n < 200; n++) begin
      s_data = d;
      s_valid = (gap == 0) || ($urandom_range(99) >= gap);
      if (poke && n == 0) begin
        load_start = 1; load_base = 8'h77; load_len = 8'h01;
      end
      if (s_valid && s_ready) begin
        @(negedge clk);
        load_start = 0; s_valid = 0;
        return;
      end
      @(negedge clk);
      load_start = 0;
    end
    s_valid = 0;
    chk("beat_timeout", 1, 0);
  endtask
  task automatic run(input logic [IAW-1:0] base, input logic [IAW-1:0] len, input int gap,
                     input bit junk, input bit pb, input bit pd, input logic [IW-1:0] w0);
    int n, k;
    logic [IAW-1:0] a;
    logic [IW-1:0] w;
    n = (len == 0) ? 256 : int'(len);
    a = base;
    start(base, len);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : {16'($urandom), 32'($urandom)};
      beat(w[31:0], gap, pb && i == 1);
      sb.push_back({a, w});
      beat({junk ? 16'hFFFF : 16'h0000, w[47:32]}, gap, 0);
      a++;
    end
    k = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("done_seen", 64'(done), 1);
    if (gap == 0) chk("latency", 64'(cyc - t0), 64'(n * 3));
    chk("pv_set", 64'(prog_valid), 1);
    if (pd) begin
      load_start = 1; load_base = 8'h33; load_len = 8'h02;
    end
    @(negedge clk);
    load_start = 0;
    chk("done_pulse", 64'(done), 0);
    chk("idle_busy", 64'(busy), 0);
    chk("pv_hold", 64'(prog_valid), 1);
    @(negedge clk);
    chk("idle_stay", 64'(s_ready), 0);
    chk("sb_empty", 64'(sb.size()), 0);
  endtask
  task automatic rst_vals(input string tag);
    chk({tag, "_ready"}, 64'(s_ready), 0);
    chk({tag, "_we"}, 64'(imem_we), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_pv"}, 64'(prog_valid), 0);
    chk({tag, "_addr"}, 64'(imem_addr), 0);
    chk({tag, "_wdata"}, 64'(IW'(imem_wdata)), 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [IW-1:0] w;
    #2;
    rst_vals("rst");
    @(negedge clk);
    rst = 1;
    run(8'h10, 8'd1, 0, 0, 0, 0, 48'hCAFE_DEADBEEF);
    run(8'h00, 8'd3, 0, 0, 0, 0, 48'h1234_5678_9ABC);
    run(8'h20, 8'd5, 40, 1, 0, 0, 48'h0F0F_A5A5_5A5A);
    run(8'hFE, 8'd3, 0, 1, 0, 0, 48'h0001_0002_0003);
    run(8'h00, 8'd0, 0, 0, 0, 0, 48'hFFFF_FFFF_FFFF);
    start(8'h00, 8'd3);
    w = 48'h1111_2222_3333;
    sb.push_back({8'h00, w});
    beat(w[31:0], 0, 0);
    beat({16'h0, w[47:32]}, 0, 0);
    beat(32'h4444_5555, 0, 0);
    #2 rst = 0;
    #1 rst_vals("midrst");
    chk("midrst_sb", 64'(sb.size()), 0);
    @(negedge clk);
    rst = 1;
    run(8'h05, 8'd2, 0, 0, 0, 0, 48'hBEEF_0000_FACE);
    run(8'h40, 8'd4, 0, 0, 1, 1, 48'h7777_8888_9999);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
